// File: rtl/s27_bist_ctrl_if.sv
// Signal bundle between the s27 BIST sequencer and its core and test host.
// The master side is the sequencer. The slave side is the core plus the host.
interface s27_bist_ctrl_if;
    logic        start;
    logic        abort;
    logic        resp;
    logic [3:0]  pat;
    logic        cut_ce;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  signature;
    logic [15:0] pat_count;

    modport master (
        input  start, abort, resp,
        output pat, cut_ce, busy, done, pass, signature, pat_count
    );

    modport slave (
        output start, abort, resp,
        input  pat, cut_ce, busy, done, pass, signature, pat_count
    );
endinterface

// File: rtl/s27_bist_ctrl.sv
// BIST sequencer for one s27 core: flush, LFSR patterns, MISR compaction, signature check.
// Latency: INIT_CYCLES + NUM_PATTERNS cycles from the start edge to done; pat and cut_ce are registered.
// Backpressure: none; start is sampled only in IDLE/DONE and abort wins from any state.
module s27_bist_ctrl #(
    parameter int unsigned NUM_PATTERNS = 64,
    parameter int unsigned INIT_CYCLES  = 2,
    parameter logic [3:0]  SEED         = 4'b0001,
    parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic             CK,
    input  logic             RN,
    s27_bist_ctrl_if.master  bus
);

    // An all-zero seed would lock the LFSR, so it is replaced by 0001.
    localparam logic [3:0]  SEED_EFF  = (SEED == 4'b0000) ? 4'b0001 : SEED;
    localparam logic [15:0] LAST_PAT  = 16'(NUM_PATTERNS - 1);
    localparam logic [7:0]  INIT_LAST = 8'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  lfsr, lfsr_nxt;
    logic [3:0]  pat_q, pat_nxt;
    logic        ce_q, ce_nxt;
    logic        pass_q, pass_nxt;
    logic [7:0]  init_cnt, init_cnt_nxt;
    logic [7:0]  sig, sig_nxt;
    logic [15:0] cnt, cnt_nxt;

    function automatic logic [3:0] lfsr_step(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic r);
        return ({s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00)) ^ {7'b0, r};
    endfunction

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pat_nxt      = 4'b0000;
        ce_nxt       = 1'b0;
        pass_nxt     = pass_q;
        lfsr_nxt     = lfsr;
        init_cnt_nxt = init_cnt;
        sig_nxt      = sig;
        cnt_nxt      = cnt;
        if (bus.abort) begin
            state_nxt = IDLE;
            pass_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_nxt    = INIT;
                        pat_nxt      = 4'b1111;
                        ce_nxt       = 1'b1;
                        pass_nxt     = 1'b0;
                        lfsr_nxt     = SEED_EFF;
                        init_cnt_nxt = INIT_LAST;
                        sig_nxt      = 8'h00;
                        cnt_nxt      = 16'h0000;
                    end
                end
                INIT: begin
                    ce_nxt = 1'b1;
                    if (init_cnt == 8'd0) begin
                        state_nxt = RUN;
                        pat_nxt   = lfsr;
                    end else begin
                        pat_nxt      = 4'b1111;
                        init_cnt_nxt = init_cnt - 8'd1;
                    end
                end
                RUN: begin
                    // Core DFFs capture on this same edge, so resp belongs to the pattern now on pat.
                    sig_nxt  = misr_step(sig, bus.resp);
                    lfsr_nxt = lfsr_step(lfsr);
                    if (cnt != 16'hFFFF) begin
                        cnt_nxt = cnt + 16'd1;
                    end
                    if (cnt == LAST_PAT) begin
                        state_nxt = DONE;
                        pass_nxt  = (sig_nxt == GOLDEN_SIG);
                    end else begin
                        pat_nxt = lfsr_nxt;
                        ce_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            pat_q    <= 4'b0000;
            ce_q     <= 1'b0;
            pass_q   <= 1'b0;
            lfsr     <= SEED_EFF;
            init_cnt <= 8'd0;
            sig      <= 8'h00;
            cnt      <= 16'h0000;
        end else begin
            pat_q    <= pat_nxt;
            ce_q     <= ce_nxt;
            pass_q   <= pass_nxt;
            lfsr     <= lfsr_nxt;
            init_cnt <= init_cnt_nxt;
            sig      <= sig_nxt;
            cnt      <= cnt_nxt;
        end
    end

    assign bus.pat       = pat_q;
    assign bus.cut_ce    = ce_q;
    assign bus.busy      = (state == INIT) || (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.pat_count = cnt;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Scoreboard bench for s27_bist_ctrl: four parameterisations, one with an s27 core model on resp.
module tb_s27_bist_ctrl;
    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic [3:0] start_v = 4'b0;
    logic [3:0] abort_v = 4'b0;
    logic       resp_tb = 1'b0;
    logic [1:0] sel = 2'd0;

    always #5 CK = ~CK;

    s27_bist_ctrl_if if_a();
    s27_bist_ctrl_if if_b();
    s27_bist_ctrl_if if_c();
    s27_bist_ctrl_if if_d();

    s27_bist_ctrl #(.NUM_PATTERNS(4),  .INIT_CYCLES(2), .SEED(4'b0001), .GOLDEN_SIG(8'h0F)) u_a (.CK(CK), .RN(RN), .bus(if_a));
    s27_bist_ctrl #(.NUM_PATTERNS(4),  .INIT_CYCLES(2), .SEED(4'b0001), .GOLDEN_SIG(8'h00)) u_b (.CK(CK), .RN(RN), .bus(if_b));
    s27_bist_ctrl #(.NUM_PATTERNS(16), .INIT_CYCLES(2), .SEED(4'b0001), .GOLDEN_SIG(8'h00)) u_c (.CK(CK), .RN(RN), .bus(if_c));
    s27_bist_ctrl u_d (.CK(CK), .RN(RN), .bus(if_d));

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_d.start = start_v[3];
    assign if_a.abort = abort_v[0];
    assign if_b.abort = abort_v[1];
    assign if_c.abort = abort_v[2];
    assign if_d.abort = abort_v[3];
    assign if_a.resp  = resp_tb;
    assign if_b.resp  = resp_tb;
    assign if_c.resp  = resp_tb;

    // s27 core: returns {G17, next G5, next G6, next G7}
    function automatic logic [3:0] s27_eval(input logic [3:0] p, input logic [2:0] st);
        logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
        g14 = ~p[0];
        g8  = g14 & st[1];
        g12 = ~(p[1] | st[0]);
        g15 = g12 | g8;
        g16 = p[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(st[2] | g9);
        g10 = ~(g14 | g11);
        g13 = ~(p[2] | g12);
        return {~g11, g10, g11, g13};
    endfunction

    logic [2:0] core_st = 3'b000;
    logic [3:0] core_out;
    assign core_out  = s27_eval(if_d.pat, core_st);
    assign if_d.resp = core_out[3];
    always @(posedge CK) if (if_d.cut_ce) core_st <= core_out[2:0];

    function automatic logic [3:0] lfsr_step(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic r);
        return ({s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00)) ^ {7'b0, r};
    endfunction

    // Observation mux: {pat, cut_ce, busy, done, pass, signature, pat_count}
    logic [31:0] vecs [4];
    assign vecs[0] = {if_a.pat, if_a.cut_ce, if_a.busy, if_a.done, if_a.pass, if_a.signature, if_a.pat_count};
    assign vecs[1] = {if_b.pat, if_b.cut_ce, if_b.busy, if_b.done, if_b.pass, if_b.signature, if_b.pat_count};
    assign vecs[2] = {if_c.pat, if_c.cut_ce, if_c.busy, if_c.done, if_c.pass, if_c.signature, if_c.pat_count};
    assign vecs[3] = {if_d.pat, if_d.cut_ce, if_d.busy, if_d.done, if_d.pass, if_d.signature, if_d.pat_count};
    logic [3:0]  m_pat;
    logic        m_ce, m_busy, m_done, m_pass;
    logic [7:0]  m_sig;
    logic [15:0] m_cnt;
    assign {m_pat, m_ce, m_busy, m_done, m_pass, m_sig, m_cnt} = vecs[sel];

    typedef struct packed {
        logic [7:0]  sig;
        logic        pass;
        logic [15:0] cnt;
    } res_t;

    logic [3:0] exp_pat_q [$];
    res_t       exp_res_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: cut_ce qualifies pat, a rising done presents the test result.
    logic       done_prev = 1'b0;
    logic [3:0] e_pat;
    res_t       e_res;
    always @(negedge CK) begin
        if (RN) begin
            if (m_ce) begin
                if (exp_pat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pat: got %0h with no pattern expected", m_pat);
                end else begin
                    e_pat = exp_pat_q.pop_front();
                    check("pat", 32'(m_pat), 32'(e_pat));
                end
            end
            if (m_done && !done_prev) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: sig %0h with no result expected", m_sig);
                end else begin
                    e_res = exp_res_q.pop_front();
                    check("signature", 32'(m_sig), 32'(e_res.sig));
                    check("pass", 32'(m_pass), 32'(e_res.pass));
                    check("pat_count", 32'(m_cnt), 32'(e_res.cnt));
                    check("busy_in_done", 32'(m_busy), 32'd0);
                end
            end
        end
        done_prev <= m_done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic wait_done(input string name, input int limit);
        int k = 0;
        while (!m_done && k < limit) begin
            tick(1);
            k++;
        end
        check(name, 32'(m_done), 32'd1);
        tick(1);
    endtask

    task automatic push_pats(input int n_init, input int n_pat);
        logic [3:0] l = 4'b0001;
        repeat (n_init) exp_pat_q.push_back(4'b1111);
        repeat (n_pat) begin
            exp_pat_q.push_back(l);
            l = lfsr_step(l);
        end
    endtask

    task automatic push_short_run(input logic [7:0] sig, input logic pass);
        logic [3:0] tbl [6] = '{4'hF, 4'hF, 4'h1, 4'h2, 4'h4, 4'h9};
        foreach (tbl[i]) exp_pat_q.push_back(tbl[i]);
        exp_res_q.push_back('{sig: sig, pass: pass, cnt: 16'd4});
    endtask

    task automatic check_idle(input string name, input logic [15:0] cnt, input logic [7:0] sig);
        check({name, "_pat"}, 32'(m_pat), 32'd0);
        check({name, "_ce"}, 32'(m_ce), 32'd0);
        check({name, "_busy"}, 32'(m_busy), 32'd0);
        check({name, "_done"}, 32'(m_done), 32'd0);
        check({name, "_pass"}, 32'(m_pass), 32'd0);
        check({name, "_sig"}, 32'(m_sig), 32'(sig));
        check({name, "_cnt"}, 32'(m_cnt), 32'(cnt));
    endtask

    task automatic pulse_start(input int idx);
        start_v[idx] = 1'b1;
        tick(1);
        start_v[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] s;
        logic [2:0] st;
        logic [3:0] l;
        logic [3:0] o;

        #2;
        sel = 2'd0;
        check_idle("reset_a", 16'd0, 8'h00);
        sel = 2'd3;
        check_idle("reset_d", 16'd0, 8'h00);
        #10 RN = 1'b1;
        tick(1);

        // Four patterns, resp=1; a start pulse mid-RUN must be ignored.
        sel = 2'd0;
        resp_tb = 1'b1;
        push_short_run(8'h0F, 1'b1);
        pulse_start(0);
        tick(3);
        pulse_start(0);
        wait_done("done_a_resp1", 20);
        check("ce_after_done", 32'(m_ce), 32'd0);
        check("pat_after_done", 32'(m_pat), 32'd0);

        // Relaunch from DONE with resp=0: golden 0F does not match.
        resp_tb = 1'b0;
        push_short_run(8'h00, 1'b0);
        pulse_start(0);
        wait_done("done_a_resp0", 20);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;

        // Golden signature 00 with resp=0 passes, with resp=1 fails.
        sel = 2'd1;
        push_short_run(8'h00, 1'b1);
        pulse_start(1);
        wait_done("done_b_resp0", 20);
        resp_tb = 1'b1;
        push_short_run(8'h0F, 1'b0);
        pulse_start(1);
        wait_done("done_b_resp1", 20);

        // abort and start together in DONE: abort wins.
        start_v[1] = 1'b1;
        abort_v[1] = 1'b1;
        tick(1);
        start_v[1] = 1'b0;
        abort_v[1] = 1'b0;
        check_idle("abort_prio", 16'd4, 8'h0F);

        // abort on the 3rd RUN cycle.
        sel = 2'd0;
        exp_pat_q.push_back(4'hF);
        exp_pat_q.push_back(4'hF);
        exp_pat_q.push_back(4'h1);
        exp_pat_q.push_back(4'h2);
        exp_pat_q.push_back(4'h4);
        pulse_start(0);
        tick(4);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;
        check_idle("abort_run", 16'd2, 8'h03);

        // Asynchronous reset during RUN, then a clean run from SEED.
        exp_pat_q.push_back(4'hF);
        exp_pat_q.push_back(4'hF);
        exp_pat_q.push_back(4'h1);
        pulse_start(0);
        tick(3);
        #1 RN = 1'b0;
        #1 check_idle("reset_run", 16'd0, 8'h00);
        #1 RN = 1'b1;
        tick(1);
        push_short_run(8'h0F, 1'b1);
        pulse_start(0);
        wait_done("done_a_after_reset", 20);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;

        // Sixteen patterns: the LFSR wraps back to 0001.
        sel = 2'd2;
        push_pats(2, 16);
        s = 8'h00;
        repeat (16) s = misr_step(s, 1'b1);
        exp_res_q.push_back('{sig: s, pass: (s == 8'h00), cnt: 16'd16});
        pulse_start(2);
        wait_done("done_c", 40);

        // Default parameters driving the s27 core, two back-to-back runs.
        sel = 2'd3;
        st = 3'b100;
        l = 4'b0001;
        s = 8'h00;
        repeat (64) begin
            o = s27_eval(l, st);
            s = misr_step(s, o[3]);
            st = o[2:0];
            l = lfsr_step(l);
        end
        repeat (2) begin
            push_pats(2, 64);
            exp_res_q.push_back('{sig: s, pass: (s == 8'h00), cnt: 16'd64});
        end
        start_v[3] = 1'b1;
        tick(1);
        check("core_resp_after_flush", 32'(if_d.resp), 32'd1);
        tick(70);
        start_v[3] = 1'b0;
        wait_done("done_d_second", 200);
        tick(2);

        check("pat_queue_empty", 32'(exp_pat_q.size()), 32'd0);
        check("res_queue_empty", 32'(exp_res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
